// File: rtl/flash_cmd_pkg.sv
// Shared opcodes, status bit positions and FSM state encoding for the
// serial-flash command sequencer.
package flash_cmd_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_PP_DATA,
        ST_RDSR,
        ST_SE_WAIT,
        ST_ERASE,
        ST_IGNORE
    } state_t;

    // Status byte as seen by RDSR; unused bits read as zero.
    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s         = 8'h00;
        s[SR_WIP] = wip;
        s[SR_WEL] = wel;
        return s;
    endfunction

endpackage

// File: rtl/flash_erase_seq.sv
// Sector erase engine: writes 0xFF to SECTOR_SIZE consecutive addresses,
// one per cycle, starting at the supplied sector base.
module flash_erase_seq
#(
    parameter int ADDR_W      = 16,
    parameter int SECTOR_SIZE = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              done
);

    localparam int CNT_W = $clog2(SECTOR_SIZE) + 1;

    logic [CNT_W-1:0] cnt;

    // Last write cycle of the sweep; lets the owner retire WEL on the same edge WIP drops.
    assign done = we && (cnt == '0);

    // Down-counter sweep: we stays high while counting down to terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            we   <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            addr <= base;
            we   <= 1'b1;
            cnt  <= CNT_W'(SECTOR_SIZE - 1);
        end else if (we) begin
            if (cnt == '0) begin
                we <= 1'b0;
            end else begin
                addr <= addr + 1'b1;
                cnt  <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_cmd_ctrl.sv
// Serial-flash command sequencer: decodes opcodes from the SPI byte stream,
// drives array reads/program writes, launches sector erases and keeps WIP/WEL.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | deselected, waiting for S to fall
// ST_CMD     | selected, next byte is the opcode
// ST_ADDR    | collecting the 3 address bytes (MSB first)
// ST_RD_DATA | READ streaming; every byte prefetches the next address
// ST_PP_DATA | page program; each byte is a read-AND-write inside the page
// ST_RDSR    | Q tracks the live status byte
// ST_SE_WAIT | SE address received, erase starts on S rise if WEL=1
// ST_ERASE   | erase running with host deselected
// ST_IGNORE  | rest of the command is discarded until S rises
module flash_cmd_ctrl
    import flash_cmd_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int PAGE_SIZE   = 256,
    parameter int SECTOR_SIZE = 4096
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [7:0]        D,
    input  logic              DATA_DONE,
    input  logic              S,
    output logic [7:0]        Q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam int PAGE_BITS = $clog2(PAGE_SIZE);
    localparam int SEC_BITS  = $clog2(SECTOR_SIZE);

    state_t            state;
    logic              s_q;
    logic              wel;
    logic [7:0]        op_q;
    logic [1:0]        addr_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] fsm_addr;
    logic              fsm_re;
    logic              fsm_we;
    logic              rd_p;
    logic              rd_v;
    logic              pp_ph;
    logic              pp_pend;
    logic [7:0]        pp_d;
    logic [7:0]        pp_pend_d;

    logic [ADDR_W-1:0] er_addr;
    logic [ADDR_W-1:0] er_base;
    logic              er_we;
    logic              er_done;
    logic              er_start;
    logic              s_fall;
    logic              s_rise;
    logic              wip;
    logic [ADDR_W-1:0] page_next;

    assign s_fall    = s_q & ~S;
    assign s_rise    = ~s_q & S;
    assign wip       = er_we;
    assign er_base   = {addr_q[ADDR_W-1:SEC_BITS], {SEC_BITS{1'b0}}};
    assign er_start  = (state == ST_SE_WAIT) && s_rise && wel;
    assign page_next = {addr_q[ADDR_W-1:PAGE_BITS], addr_q[PAGE_BITS-1:0] + PAGE_BITS'(1)};

    flash_erase_seq #(
        .ADDR_W      (ADDR_W),
        .SECTOR_SIZE (SECTOR_SIZE)
    ) u_erase (
        .clk   (clk),
        .rst   (RESET),
        .start (er_start),
        .base  (er_base),
        .addr  (er_addr),
        .we    (er_we),
        .done  (er_done)
    );

    // The erase engine owns the array port while it runs; PP write data is the
    // old byte (valid the cycle after mem_re) ANDed with the received byte.
    assign mem_addr  = er_we ? er_addr : fsm_addr;
    assign mem_re    = fsm_re;
    assign mem_we    = er_we | fsm_we;
    assign mem_wdata = er_we ? 8'hFF : (fsm_we ? (mem_rdata & pp_d) : 8'h00);
    assign busy      = er_we;

    // Command FSM with registered array strobes, Q and status.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            s_q       <= 1'b1;
            wel       <= 1'b0;
            op_q      <= 8'h00;
            addr_cnt  <= 2'd0;
            addr_q    <= '0;
            fsm_addr  <= '0;
            fsm_re    <= 1'b0;
            fsm_we    <= 1'b0;
            rd_p      <= 1'b0;
            rd_v      <= 1'b0;
            pp_ph     <= 1'b0;
            pp_pend   <= 1'b0;
            pp_d      <= 8'h00;
            pp_pend_d <= 8'h00;
            Q         <= 8'h00;
        end else begin
            s_q    <= S;
            fsm_re <= 1'b0;
            fsm_we <= 1'b0;
            rd_p   <= 1'b0;
            rd_v   <= rd_p;
            if (rd_v) begin
                Q <= mem_rdata;
            end
            // Second half of a PP read-modify-write completes even if S has risen.
            if (pp_ph) begin
                fsm_we <= 1'b1;
                pp_ph  <= 1'b0;
                addr_q <= page_next;
            end
            if (er_done) begin
                wel <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (s_fall) begin
                        state <= ST_CMD;
                        op_q  <= 8'h00;
                        Q     <= 8'h00;
                    end
                end
                ST_ERASE: begin
                    if (er_done) begin
                        state <= ST_IDLE;
                    end else if (s_fall) begin
                        state <= ST_CMD;
                        op_q  <= 8'h00;
                        Q     <= 8'h00;
                    end
                end
                default: begin
                    if (s_rise) begin
                        pp_pend <= 1'b0;
                        if (er_start) begin
                            state <= ST_ERASE;
                        end else begin
                            state <= ST_IDLE;
                            case (op_q)
                                OP_WREN:              wel <= 1'b1;
                                OP_WRDI, OP_PP, OP_SE: wel <= 1'b0;
                                default: ;
                            endcase
                        end
                    end else begin
                        case (state)
                            ST_CMD: begin
                                if (DATA_DONE) begin
                                    op_q <= D;
                                    if (wip && (D != OP_RDSR)) begin
                                        op_q  <= 8'h00;
                                        state <= ST_IGNORE;
                                    end else begin
                                        case (D)
                                            OP_RDSR: begin
                                                state <= ST_RDSR;
                                                Q     <= status_byte(wel, wip);
                                            end
                                            OP_READ, OP_PP, OP_SE: begin
                                                addr_cnt <= 2'd0;
                                                state    <= ST_ADDR;
                                            end
                                            default: state <= ST_IGNORE;
                                        endcase
                                    end
                                end
                            end
                            ST_ADDR: begin
                                if (DATA_DONE) begin
                                    addr_q   <= {addr_q[ADDR_W-9:0], D};
                                    addr_cnt <= addr_cnt + 2'd1;
                                    if (addr_cnt == 2'd2) begin
                                        if (op_q == OP_READ) begin
                                            fsm_addr <= {addr_q[ADDR_W-9:0], D};
                                            fsm_re   <= 1'b1;
                                            rd_p     <= 1'b1;
                                            state    <= ST_RD_DATA;
                                        end else if (op_q == OP_PP) begin
                                            state <= ST_PP_DATA;
                                        end else begin
                                            state <= ST_SE_WAIT;
                                        end
                                    end
                                end
                            end
                            ST_RD_DATA: begin
                                if (DATA_DONE) begin
                                    addr_q   <= addr_q + 1'b1;
                                    fsm_addr <= addr_q + 1'b1;
                                    fsm_re   <= 1'b1;
                                    rd_p     <= 1'b1;
                                end
                            end
                            ST_PP_DATA: begin
                                if (wel) begin
                                    if (!pp_ph && (DATA_DONE || pp_pend)) begin
                                        fsm_addr <= addr_q;
                                        fsm_re   <= 1'b1;
                                        pp_ph    <= 1'b1;
                                        pp_d     <= pp_pend ? pp_pend_d : D;
                                        if (pp_pend && DATA_DONE) begin
                                            pp_pend_d <= D;
                                        end else begin
                                            pp_pend <= 1'b0;
                                        end
                                    end else if (DATA_DONE) begin
                                        pp_pend   <= 1'b1;
                                        pp_pend_d <= D;
                                    end
                                end
                            end
                            ST_RDSR: begin
                                Q <= status_byte(wel, wip);
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_cmd_ctrl.sv
// Bench for flash_cmd_ctrl: byte-level SPI driver, array model, reference
// memory image and a scoreboard of expected Q bytes checked by a monitor.
module tb_flash_cmd_ctrl;

    logic        clk = 1'b0;
    logic        RESET;
    logic [7:0]  D;
    logic        DATA_DONE;
    logic        S;
    logic [7:0]  Q;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    typedef struct {
        logic [7:0] val;
        int         tag;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         failures = 0;
    int         busy_cyc = 0;
    int         we_cyc = 0;
    int         re_cyc = 0;
    int         ovl_cyc = 0;
    int         byte_tag = 0;
    logic [7:0] tb_mem  [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic       wel_m;
    logic       wip_m;

    flash_cmd_ctrl #(
        .ADDR_W      (16),
        .PAGE_SIZE   (256),
        .SECTOR_SIZE (4096)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .D         (D),
        .DATA_DONE (DATA_DONE),
        .S         (S),
        .Q         (Q),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 16'h1234) return 8'hAA;
        if (i == 16'h1235) return 8'h55;
        if (i == 16'h01FE || i == 16'h01FF || i == 16'h0100) return 8'hFF;
        return 8'((i * 7 + (i >> 8) * 13 + 60) ^ (i >> 3));
    endfunction

    // Array model: read data appears the cycle after mem_re.
    initial begin
        for (int i = 0; i < 65536; i++) tb_mem[i] = init_byte(i);
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (mem_we) we_cyc++;
            if (mem_re) re_cyc++;
            if (mem_re && mem_we) ovl_cyc++;
            if (!RESET && DATA_DONE) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("q_byte%0d", e.tag), Q, e.val);
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] exp);
        exp_t e;
        repeat (16) @(posedge clk);
        #1;
        D         = d;
        DATA_DONE = 1'b1;
        e.val     = exp;
        e.tag     = byte_tag;
        byte_tag++;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        DATA_DONE = 1'b0;
    endtask

    task automatic cs_low();
        @(posedge clk);
        #1 S = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic cs_high();
        repeat (16) @(posedge clk);
        #1 S = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    function automatic logic [7:0] status_m();
        return {6'b0, wel_m, wip_m};
    endfunction

    task automatic do_simple(input logic [7:0] op);
        cs_low();
        send(op, 8'h00);
        cs_high();
        if (!wip_m && op == 8'h06) wel_m = 1'b1;
        if (!wip_m && op == 8'h04) wel_m = 1'b0;
    endtask

    task automatic do_rdsr(input int n);
        cs_low();
        send(8'h05, 8'h00);
        for (int j = 0; j < n; j++) send(8'($urandom), status_m());
        cs_high();
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [15:0] ra;
        cs_low();
        send(8'h03, 8'h00);
        send(a[23:16], 8'h00);
        send(a[15:8], 8'h00);
        send(a[7:0], 8'h00);
        for (int j = 0; j < n; j++) begin
            ra = a[15:0] + 16'(j);
            send(8'($urandom), ref_mem[ra]);
        end
        cs_high();
    endtask

    task automatic do_pp(input logic [23:0] a, input int n, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2, input logic rnd);
        logic [7:0]  d;
        logic [15:0] pa;
        cs_low();
        send(8'h02, 8'h00);
        send(a[23:16], 8'h00);
        send(a[15:8], 8'h00);
        send(a[7:0], 8'h00);
        for (int i = 0; i < n; i++) begin
            if (rnd) d = 8'($urandom);
            else     d = (i == 0) ? d0 : ((i == 1) ? d1 : d2);
            send(d, 8'h00);
            if (wel_m) begin
                pa = {a[15:8], 8'(a[7:0] + 8'(i))};
                ref_mem[pa] = ref_mem[pa] & d;
            end
        end
        cs_high();
        wel_m = 1'b0;
    endtask

    task automatic mem_compare(input string name);
        int mism;
        int first;
        mism  = 0;
        first = -1;
        for (int i = 0; i < 65536; i++) begin
            if (tb_mem[i] !== ref_mem[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        if (mism != 0) $display("  first differing address %0h", first);
        chk(name, mism, 0);
    endtask

    initial begin
        int b0, w0, r0, n;
        RESET     = 1'b1;
        S         = 1'b1;
        D         = 8'h00;
        DATA_DONE = 1'b0;
        wel_m     = 1'b0;
        wip_m     = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_q", Q, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 RESET = 1'b0;
        repeat (4) @(posedge clk);

        // Status register: WREN / RDSR / WRDI.
        do_simple(8'h06);
        do_rdsr(2);
        do_simple(8'h04);
        do_rdsr(1);

        // Preloaded read and address wrap at the top of the array.
        do_read(24'h001234, 2);
        do_read(24'h00FFFF, 2);

        // Page program with in-page wrap, WEL retired afterwards.
        do_simple(8'h06);
        do_pp(24'h0001FE, 3, 8'h0F, 8'hF0, 8'h33, 1'b0);
        chk("pp_01fe", tb_mem[16'h01FE], 8'h0F);
        chk("pp_01ff", tb_mem[16'h01FF], 8'hF0);
        chk("pp_0100", tb_mem[16'h0100], 8'h33);
        mem_compare("mem_after_pp");
        do_rdsr(1);

        // Program without WREN writes nothing.
        w0 = we_cyc;
        do_pp(24'h00ABCD, 3, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("pp_nowel_we", we_cyc - w0, 0);
        mem_compare("mem_after_pp_nowel");

        // Sector erase with RDSR and an ignored READ while WIP=1.
        do_simple(8'h06);
        cs_low();
        send(8'h20, 8'h00);
        send(8'h00, 8'h00);
        send(8'h23, 8'h00);
        send(8'h45, 8'h00);
        repeat (16) @(posedge clk);
        #1 S = 1'b1;
        b0 = busy_cyc;
        w0 = we_cyc;
        @(negedge clk);
        chk("busy_before_rise", busy, 0);
        @(negedge clk);
        chk("busy_rise", busy, 1);
        wip_m = 1'b1;
        repeat (4) @(posedge clk);
        do_rdsr(2);
        r0 = re_cyc;
        cs_low();
        for (int j = 0; j < 6; j++) send((j == 0) ? 8'h03 : 8'h00, 8'h00);
        cs_high();
        chk("wip_read_no_re", re_cyc - r0, 0);
        n = 0;
        while (busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("erase_timeout", busy, 0);
        chk("erase_busy_cycles", busy_cyc - b0, 4096);
        chk("erase_we_cycles", we_cyc - w0, 4096);
        for (int i = 16'h2000; i <= 16'h2FFF; i++) ref_mem[i] = 8'hFF;
        wip_m = 1'b0;
        wel_m = 1'b0;
        mem_compare("mem_after_erase");
        do_rdsr(1);

        // S rises after two READ address bytes: no array access, back to IDLE.
        r0 = re_cyc;
        cs_low();
        send(8'h03, 8'h00);
        send(8'h00, 8'h00);
        send(8'h12, 8'h00);
        cs_high();
        chk("abort_no_re", re_cyc - r0, 0);
        do_rdsr(1);

        // Randomized command mix against the reference image.
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0: do_read(24'($urandom), int'($urandom_range(1, 4)));
                1: begin
                    if ($urandom_range(0, 1) == 1) do_simple(8'h06);
                    do_pp(24'($urandom), int'($urandom_range(1, 5)), 8'h00, 8'h00, 8'h00, 1'b1);
                    mem_compare($sformatf("mem_rand_pp%0d", it));
                end
                default: do_rdsr(int'($urandom_range(1, 3)));
            endcase
        end

        // Reset in the middle of an erase.
        do_simple(8'h06);
        cs_low();
        send(8'h20, 8'h00);
        send(8'h00, 8'h00);
        send(8'h51, 8'h00);
        send(8'h00, 8'h00);
        cs_high();
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("mid_erase_busy", busy, 1);
        @(posedge clk);
        #1 RESET = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_q", Q, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        chk("rst_mid_mem_re", mem_re, 0);
        chk("rst_mid_mem_we", mem_we, 0);
        chk("rst_mid_mem_wdata", mem_wdata, 0);
        repeat (3) @(posedge clk);
        #1 RESET = 1'b0;
        wel_m = 1'b0;
        wip_m = 1'b0;
        repeat (4) @(posedge clk);
        do_rdsr(1);

        repeat (20) @(posedge clk);
        chk("sb_empty", sb_q.size(), 0);
        chk("re_we_overlap", ovl_cyc, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_cmd_ctrl.md
# flash_cmd_ctrl

Command sequencer between the SPI slave byte front-end and the flash memory array. Decodes the serial-flash opcode stream (D/DATA_DONE under chip select S) and sequences the array reads, program writes and sector erases. Maintains the status register (WIP/WEL) and supplies the next outgoing byte on Q for the MISO shifter.

## Interface
- ADDR_W, 16: array address width; the low ADDR_W bits of the 24-bit SPI address are used.
- PAGE_SIZE, 256: program page size in bytes (power of 2).
- SECTOR_SIZE, 4096: erase sector size in bytes (power of 2, ≤ 2^ADDR_W).

- clk  in  1  system clock
- RESET  in  1  asynchronous active-high reset
- D  in  8  received byte, valid when DATA_DONE=1
- DATA_DONE  in  1  one-cycle byte-received strobe
- S  in  1  chip select, active-low (1 = deselected)
- Q  out  8  byte to shift out during the next SPI byte
- mem_addr  out  ADDR_W  array address
- mem_re  out  1  array read strobe; mem_rdata valid the next cycle
- mem_we  out  1  array write strobe
- mem_wdata  out  8  array write data
- mem_rdata  in  8  array read data
- busy  out  1  copy of status WIP

## Operation
- Opcodes: 06 WREN, 04 WRDI, 05 RDSR, 03 READ, 02 PP, 20 SE. All others go to IGNORE until S rises.
- Status byte: bit0 WIP, bit1 WEL, bits 7:2 = 0.
- States: IDLE, CMD, ADDR, RD_DATA, PP_DATA, RDSR, SE_WAIT, ERASE, IGNORE.
- S falling: IDLE→CMD. The first DATA_DONE byte is the opcode.
- WREN/WRDI: set/clear WEL on S rise. RDSR: Q = live status for every following byte.
- READ/PP/SE: the next 3 bytes are the address (MSB first) and load addr_q.
- READ: array read on the 3rd address byte. Q = mem_rdata. addr_q increments per DATA_DONE, wraps at 2^ADDR_W, and prefetches the next byte.
- PP (WEL=1 only): per data byte, read then write mem_wdata = old & D. The address increments inside the page; the low log2(PAGE_SIZE) bits wrap and the upper bits are held. With WEL=0 the bytes are ignored.
- SE: after 3 address bytes go to SE_WAIT. On S rise with WEL=1, enter ERASE: sector base = addr_q with the low log2(SECTOR_SIZE) bits cleared, then write 0xFF to one address per cycle for SECTOR_SIZE cycles. WIP=1 throughout; at the end WIP=0, WEL=0, then IDLE.
- WEL clears on the S rise that ends a PP or SE command.
- While WIP=1, only RDSR is accepted; any other opcode → IGNORE.
- S rise in any state except ERASE aborts to IDLE. PP bytes already written are kept. The S rise that arrives during SE_WAIT starts the erase.

## Timing
- Reset values: Q=00, mem_addr=0, mem_re=0, mem_we=0, mem_wdata=00, busy=0, WEL=0, state IDLE.
- Q is valid no later than 3 clk cycles after the DATA_DONE that requests it, and holds until the next DATA_DONE.
- The PP read-modify-write takes 2 cycles: mem_re in cycle N, mem_we in cycle N+1.
- mem_re and mem_we are single-cycle and never asserted together.
- The erase takes exactly SECTOR_SIZE cycles with mem_we high. busy rises the cycle after the S rise and falls the cycle after the last write.
- DATA_DONE arriving while a PP write is pending is queued for one byte. The SPI byte period (≥16 clk) guarantees no overrun.
- RESET during ERASE aborts immediately; the partial erase remains.

## Structure
- Package flash_cmd_pkg holds: opcode constants, state enum, status bit indices.
- Sub-module flash_erase_seq implements the sector erase. Inputs: start, base address. Outputs: address counter, we, done.

## Test plan
- WREN, then RDSR for 2 bytes → Q=02, 02. Then WRDI followed by RDSR → Q=00.
- Array preloaded with 0x1234=AA, 0x1235=55. Send READ 00 12 34 + 2 dummy bytes → Q=AA then 55. The read at FFFF wraps to 0000.
- WREN, then PP 00 01 FE with 3 bytes 0F F0 33 over FF → addr 01FE=0F, 01FF=F0, 0100=33 (page wrap). RDSR afterwards → WEL=0.
- WREN, then SE 00 23 45 → 4096 writes of FF to 2000..2FFF. RDSR during the erase → 03. busy is high for 4096 cycles.
- PP without WREN → no mem_we. READ 00 00 issued while WIP=1 → ignored, Q=00.
- S rises after 2 address bytes of READ → back to IDLE with no mem_re. RESET mid-erase → busy=0 and all outputs at reset values.
